fp_add_pipe: RTL and testbench

- Parametrised, pipelined sign-magnitude floating-point adder/subtractor; successor to the single-cycle combinational adder in the arithmetic datapath.
- Generalises exponent and mantissa widths, adds an explicit add/sub mode, correct alignment, normalisation, saturation and status flags.
- Valid/ready handshake on both sides so it slots into streaming multiplier/accumulator chains.

---
 rtl/fp_add_pkg.sv | 14 +
 rtl/fp_lzc.sv | 24 ++
 rtl/fp_add_pipe.sv | 168 ++++++++++++++++
 tb/tb_fp_add_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared constants and types for the pipelined sign-magnitude floating-point adder.
// Values are (-1)^sign * man * 2^exp with an unbiased exponent and an explicit mantissa MSB.
package fp_add_pkg;

  localparam int DEF_EXP_W = 3;
  localparam int DEF_MAN_W = 8;

  typedef struct packed {
    logic                 sign;
    logic [DEF_EXP_W-1:0] exp;
    logic [DEF_MAN_W-1:0] man;
  } fp_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter: number of zeros above the highest set bit, plus an all-zero flag.
module fp_lzc
  import fp_add_pkg::*;
#(
  parameter int W = DEF_MAN_W
) (
  input  logic [W-1:0]           din,
  output logic [$clog2(W+1)-1:0] cnt,
  output logic                   all_zero
);

  localparam int CNT_W = $clog2(W + 1);

  // Scanning upward lets the highest set bit have the last word.
  always_comb begin
    cnt = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CNT_W'(W - 1 - i);
    end
  end

  assign all_zero = ~|din;

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (align, add, normalise)
// with valid/ready handshakes on both sides and ovf/zero status.
module fp_add_pipe
  import fp_add_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_sign,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [MAN_W-1:0] a_man,
  input  logic             b_sign,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] b_man,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_sign,
  output logic [EXP_W-1:0] res_exp,
  output logic [MAN_W-1:0] res_man,
  output logic             ovf,
  output logic             zero
);

  localparam int LZ_W = $clog2(MAN_W + 1);
  localparam int SH_W = (LZ_W > EXP_W) ? LZ_W : EXP_W;

  typedef struct packed {
    logic             sign_l;
    logic             sign_s;
    logic [EXP_W-1:0] exp_l;
    logic [MAN_W-1:0] man_l;
    logic [MAN_W-1:0] man_s;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sum;
  } s2_t;

  logic s1_valid, s2_valid;
  logic s1_ready, s2_ready, s3_ready;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  assign s3_ready = !out_valid || out_ready;
  assign s2_ready = !s2_valid || s3_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  // S1: order operands so L has the larger magnitude, then align S to L.
  logic             b_sign_eff, a_is_l;
  logic [EXP_W-1:0] exp_diff;
  logic [MAN_W-1:0] man_small;

  always_comb begin
    s1_d       = '0;
    exp_diff   = '0;
    man_small  = '0;
    b_sign_eff = b_sign ^ sub;
    a_is_l     = (a_exp > b_exp) || ((a_exp == b_exp) && (a_man >= b_man));
    if (a_is_l) begin
      s1_d.sign_l = a_sign;
      s1_d.sign_s = b_sign_eff;
      s1_d.exp_l  = a_exp;
      s1_d.man_l  = a_man;
      man_small   = b_man;
      exp_diff    = a_exp - b_exp;
    end else begin
      s1_d.sign_l = b_sign_eff;
      s1_d.sign_s = a_sign;
      s1_d.exp_l  = b_exp;
      s1_d.man_l  = b_man;
      man_small   = a_man;
      exp_diff    = b_exp - a_exp;
    end
    if (int'(exp_diff) >= MAN_W) s1_d.man_s = '0;
    else                         s1_d.man_s = man_small >> exp_diff;
  end

  // S2: magnitude add or subtract; the S1 ordering keeps the difference non-negative.
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign_l;
    s2_d.exp  = s1_q.exp_l;
    if (s1_q.sign_l != s1_q.sign_s) s2_d.sum = {1'b0, s1_q.man_l} - {1'b0, s1_q.man_s};
    else                            s2_d.sum = {1'b0, s1_q.man_l} + {1'b0, s1_q.man_s};
  end

  // S3: normalise, saturate on carry out of the top exponent, flag exact zero.
  logic [LZ_W-1:0]  lz;
  logic             sum_lo_zero;
  logic [SH_W-1:0]  lz_x, exp_x, shift;
  logic             r_sign, r_ovf, r_zero;
  logic [EXP_W-1:0] r_exp;
  logic [MAN_W-1:0] r_man;

  fp_lzc #(.W(MAN_W)) u_lzc (
    .din      (s2_q.sum[MAN_W-1:0]),
    .cnt      (lz),
    .all_zero (sum_lo_zero)
  );

  always_comb begin
    r_sign = s2_q.sign;
    r_exp  = s2_q.exp;
    r_man  = '0;
    r_ovf  = 1'b0;
    r_zero = 1'b0;
    lz_x   = SH_W'(lz);
    exp_x  = SH_W'(s2_q.exp);
    // A denormal stops normalising once the exponent reaches zero.
    shift  = (lz_x < exp_x) ? lz_x : exp_x;
    if (s2_q.sum[MAN_W]) begin
      if (&s2_q.exp) begin
        r_ovf = 1'b1;
        r_exp = '1;
        r_man = '1;
      end else begin
        r_exp = s2_q.exp + EXP_W'(1);
        r_man = s2_q.sum[MAN_W:1];
      end
    end else if (sum_lo_zero) begin
      r_sign = 1'b0;
      r_exp  = '0;
      r_zero = 1'b1;
    end else begin
      r_man = s2_q.sum[MAN_W-1:0] << shift;
      r_exp = s2_q.exp - EXP_W'(shift);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      res_sign  <= 1'b0;
      res_exp   <= '0;
      res_man   <= '0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (s1_ready) s1_valid  <= in_valid;
      if (s2_ready) s2_valid  <= s1_valid;
      if (s3_ready) out_valid <= s2_valid;
      if (s3_ready && s2_valid) begin
        res_sign <= r_sign;
        res_exp  <= r_exp;
        res_man  <= r_man;
        ovf      <= r_ovf;
        zero     <= r_zero;
      end
    end
  end

  // NOTE: payload registers carry no reset; the valid bits alone decide whether their contents matter.
  always_ff @(posedge clk) begin
    if (in_valid && s1_ready) s1_q <= s1_d;
    if (s1_valid && s2_ready) s2_q <= s2_d;
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: the driver queues hand-computed results on accept,
// a free-running monitor pops and compares on every output handshake.
module tb_fp_add_pipe;
  import fp_add_pkg::*;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       a_sign = 1'b0, b_sign = 1'b0, sub = 1'b0;
  logic [2:0] a_exp = '0, b_exp = '0;
  logic [7:0] a_man = '0, b_man = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       res_sign, ovf, zero;
  logic [2:0] res_exp;
  logic [7:0] res_man;

  fp_add_pipe #(.EXP_W(3), .MAN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_sign    (a_sign),
    .a_exp     (a_exp),
    .a_man     (a_man),
    .b_sign    (b_sign),
    .b_exp     (b_exp),
    .b_man     (b_man),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_sign  (res_sign),
    .res_exp   (res_exp),
    .res_man   (res_man),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #HALF clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {sign, exp, man, ovf, zero}
  logic [13:0] dut_res;
  assign dut_res = {res_sign, res_exp, res_man, ovf, zero};

  typedef struct {
    logic [13:0] res;
    int          acc_cyc;
    bit          chk_lat;
    int          id;
  } exp_t;

  typedef struct packed {
    fp_t         a;
    fp_t         b;
    logic        s;
    logic [13:0] want;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   next_id = 0;
  bit   stall_seen = 1'b0;

  function automatic fp_t mk(input logic s, input logic [2:0] e, input logic [7:0] m);
    return {s, e, m};
  endfunction

  function automatic logic [13:0] rs(input logic s, input logic [2:0] e, input logic [7:0] m,
                                     input logic o, input logic z);
    return {s, e, m, o, z};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input fp_t a, input fp_t b, input logic s, input logic [13:0] want,
                       input bit push, input bit chk_lat);
    bit   done = 1'b0;
    int   waited = 0;
    exp_t e;
    in_valid = 1'b1;
    {a_sign, a_exp, a_man} = a;
    {b_sign, b_exp, b_man} = b;
    sub = s;
    while (!done) begin
      #(HALF - 1);
      if (in_ready) begin
        if (push) begin
          e.res     = want;
          e.acc_cyc = cyc;
          e.chk_lat = chk_lat;
          e.id      = next_id;
          sb_q.push_back(e);
        end
        next_id++;
        done = 1'b1;
      end else begin
        stall_seen = 1'b1;
        waited++;
        if (waited > 50) begin
          check("accept_timeout", {31'd0, in_ready}, 32'd1);
          done = 1'b1;
        end
      end
      @(negedge clk);
    end
  endtask

  // Idle cycles with random data on the bus; none of it may be taken.
  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      {a_sign, a_exp, a_man, b_sign, b_exp, b_man, sub} = 25'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb_q.size(), 32'd0);
  endtask

  // Monitor: compares on handshake, and checks outputs hold while stalled.
  initial begin
    logic [13:0] held;
    bit          hold;
    exp_t        e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #(HALF - 1);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", {31'd0, out_valid}, 32'd1);
          check("hold_data", {18'd0, dut_res}, {18'd0, held});
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("spurious_out", {31'd0, out_valid}, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("op%0d_result", e.id), {18'd0, dut_res}, {18'd0, e.res});
            if (e.chk_lat) check($sformatf("op%0d_latency", e.id), cyc - e.acc_cyc, 32'd3);
          end
        end
        hold = out_valid && !out_ready;
        held = dut_res;
      end
    end
  end

  vec_t dir_v [8];
  vec_t str_v [6];

  initial begin
    dir_v[0] = '{mk(0, 2, 8'h80), mk(0, 2, 8'h80), 1'b0, rs(0, 3, 8'h80, 0, 0)};
    dir_v[1] = '{mk(0, 3, 8'h80), mk(0, 1, 8'h80), 1'b1, rs(0, 2, 8'hC0, 0, 0)};
    dir_v[2] = '{mk(0, 4, 8'h90), mk(1, 4, 8'h90), 1'b0, rs(0, 0, 8'h00, 0, 1)};
    dir_v[3] = '{mk(0, 7, 8'hFF), mk(0, 7, 8'hFF), 1'b0, rs(0, 7, 8'hFF, 1, 0)};
    dir_v[4] = '{mk(1, 4, 8'h90), mk(0, 4, 8'h90), 1'b0, rs(0, 0, 8'h00, 0, 1)};
    dir_v[5] = '{mk(0, 7, 8'h80), mk(0, 0, 8'hFF), 1'b0, rs(0, 7, 8'h81, 0, 0)};
    dir_v[6] = '{mk(0, 6, 8'hFF), mk(0, 6, 8'hFF), 1'b0, rs(0, 7, 8'hFF, 0, 0)};
    dir_v[7] = '{mk(1, 3, 8'hC0), mk(1, 3, 8'hC0), 1'b1, rs(0, 0, 8'h00, 0, 1)};

    str_v[0] = '{mk(0, 1, 8'hA0), mk(0, 3, 8'h40), 1'b0, rs(0, 2, 8'hD0, 0, 0)};
    str_v[1] = '{mk(1, 5, 8'hC0), mk(0, 5, 8'h80), 1'b0, rs(1, 4, 8'h80, 0, 0)};
    str_v[2] = '{mk(0, 2, 8'h80), mk(0, 2, 8'h90), 1'b1, rs(1, 0, 8'h40, 0, 0)};
    str_v[3] = '{mk(0, 1, 8'h80), mk(0, 0, 8'hC0), 1'b1, rs(0, 0, 8'h40, 0, 0)};
    // Truncated alignment drops B's only set bit, leaving 0x01 at e1 rescaled to 0x02 at e0.
    str_v[4] = '{mk(0, 1, 8'h01), mk(0, 0, 8'h01), 1'b1, rs(0, 0, 8'h02, 0, 0)};
    str_v[5] = '{mk(0, 2, 8'h81), mk(0, 0, 8'hFF), 1'b0, rs(0, 2, 8'hC0, 0, 0)};

    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_result", {18'd0, dut_res}, 32'd0);

    idle(4);

    // Isolated operations: result and 3-cycle latency.
    for (int i = 0; i < 8; i++) begin
      issue(dir_v[i].a, dir_v[i].b, dir_v[i].s, dir_v[i].want, 1'b1, 1'b1);
      idle(5);
    end
    drain();

    // Back-to-back stream with the sink stalled for cycles 2-7.
    fork
      begin
        for (int i = 0; i < 6; i++) issue(str_v[i].a, str_v[i].b, str_v[i].s, str_v[i].want, 1'b1, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_backpressure", {31'd0, stall_seen}, 32'd1);
    idle(3);

    // Reset with two operations in flight; neither may surface.
    issue(mk(0, 5, 8'hAA), mk(0, 5, 8'h55), 1'b0, '0, 1'b0, 1'b0);
    issue(mk(1, 2, 8'hF0), mk(0, 1, 8'h80), 1'b0, '0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_flush_in_ready", {31'd0, in_ready}, 32'd1);
    idle(8);
    issue(mk(0, 0, 8'h80), mk(0, 0, 8'h80), 1'b0, rs(0, 1, 8'h80, 0, 0), 1'b1, 1'b1);
    idle(5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
